qspi_mem_arbiter: RTL and testbench



---
 rtl/qspi_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_qspi_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_arbiter.sv
// qspi_mem_arbiter
//   Round-robin arbiter sharing one off-chip QSPI XIP bus (RAM/ROM chip
//   selects, SCK, 4-bit SD) between NUM_REQ core-side QSPI masters.
//   A registered IDLE/GRANT/GUARD FSM issues a one-hot grant and inserts
//   GUARD_CYCLES idle bus cycles between two owners.
//
//   Build option: define QSPI_ARB_TIMEOUT_EN to bound each grant to
//   TIMEOUT_CYCLES cycles (forced release, timeout_o pulse, requester
//   blocked until it drops and re-raises req_i). Undefined: grants are
//   unbounded and timeout_o is tied low.
//
// Ports
//   clk_i, rst_in                 clock, async active-low reset
//   en_i, req_i                   per-requester enable mask and request
//   gnt_o                         registered one-hot grant
//   req_cs_ram_n_i/_rom_n_i/sck_i per-requester bus outputs (1 bit each)
//   req_sd_o_i, req_oen_i         per-requester data/oe, nibble k = [4k+3:4k]
//   req_sd_i_o                    bus data-in broadcast to requesters
//   qspi_mem_*                    pad-side bus (oen active-high drive)
//   busy_o, owner_o, timeout_o    status
module qspi_mem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_in,
  input  logic [NUM_REQ-1:0]           en_i,
  input  logic [NUM_REQ-1:0]           req_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  input  logic [NUM_REQ-1:0]           req_cs_ram_n_i,
  input  logic [NUM_REQ-1:0]           req_cs_rom_n_i,
  input  logic [NUM_REQ-1:0]           req_sck_i,
  input  logic [4*NUM_REQ-1:0]         req_sd_o_i,
  input  logic [4*NUM_REQ-1:0]         req_oen_i,
  output logic [3:0]                   req_sd_i_o,
  output logic                         qspi_mem_cs_ram_on,
  output logic                         qspi_mem_cs_rom_on,
  output logic                         qspi_mem_sck_o,
  output logic [3:0]                   qspi_mem_sd_o,
  output logic [3:0]                   qspi_mem_oen_o,
  input  logic [3:0]                   qspi_mem_sd_i,
  output logic                         busy_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         timeout_o
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [NUM_REQ-1:0] blk;
  logic [NUM_REQ-1:0] elig;
  logic               pick_vld;
  logic [OW-1:0]      pick_idx;
  logic               owner_req, owner_en;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic               tmo_pulse_q, tmo_pulse_d;
  // A timed-out requester stays blocked until it lets go of req_i.
  logic [NUM_REQ-1:0] blk_q, blk_d;
  assign blk       = blk_q;
  assign timeout_o = tmo_pulse_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign blk        = '0;
  assign timeout_o  = 1'b0;
`endif

  assign elig      = req_i & en_i & ~blk;
  assign owner_req = req_i[owner_q];
  assign owner_en  = en_i[owner_q];

  // First eligible index after the current owner, scanning cyclically.
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = owner_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == (int'(owner_q) + i) % NUM_REQ && elig[j]) begin
          pick_vld = 1'b1;
          pick_idx = OW'(j);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    guard_d = guard_q;
`ifdef QSPI_ARB_TIMEOUT_EN
    tmo_cnt_d   = '0;
    tmo_pulse_d = 1'b0;
    blk_d       = blk_q & req_i;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
        end
      end
      S_GRANT: begin
        if (!owner_req || !owner_en) begin
          state_d = S_GUARD;
          gnt_d   = '0;
          guard_d = '0;
        end
`ifdef QSPI_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_GUARD;
          gnt_d       = '0;
          guard_d     = '0;
          tmo_pulse_d = 1'b1;
          blk_d       = blk_d | (NUM_REQ'(1) << owner_q);
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      S_GUARD: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) begin
          if (pick_vld) begin
            state_d = S_GRANT;
            owner_d = pick_idx;
            gnt_d   = NUM_REQ'(1) << pick_idx;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      owner_q <= OW'(NUM_REQ - 1);
      gnt_q   <= '0;
      guard_q <= '0;
`ifdef QSPI_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
      blk_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      guard_q <= guard_d;
`ifdef QSPI_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
      blk_q       <= blk_d;
`endif
    end
  end

  // Bus mux: owner's pins only while in GRANT, idle levels otherwise.
  // Keyed off the registered state so reset idles the bus immediately.
  always_comb begin
    qspi_mem_cs_ram_on = 1'b1;
    qspi_mem_cs_rom_on = 1'b1;
    qspi_mem_sck_o     = 1'b0;
    qspi_mem_sd_o      = 4'h0;
    qspi_mem_oen_o     = 4'h0;
    if (state_q == S_GRANT) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (owner_q == OW'(j)) begin
          qspi_mem_cs_ram_on = req_cs_ram_n_i[j];
          qspi_mem_cs_rom_on = req_cs_rom_n_i[j];
          qspi_mem_sck_o     = req_sck_i[j];
          qspi_mem_sd_o      = req_sd_o_i[4*j +: 4];
          qspi_mem_oen_o     = req_oen_i[4*j +: 4];
        end
      end
    end
  end

  assign req_sd_i_o = qspi_mem_sd_i;
  assign gnt_o      = gnt_q;
  assign busy_o     = (state_q == S_GRANT);
  assign owner_o    = owner_q;
endmodule

// File: tb/tb_qspi_mem_arbiter.sv
module tb_qspi_mem_arbiter;
  localparam int N = 4;
  localparam int G = 2;
  localparam int T = 16;

  logic           clk, rst_n;
  logic [N-1:0]   en, req, gnt;
  logic [N-1:0]   r_cs_ram, r_cs_rom, r_sck;
  logic [4*N-1:0] r_sd, r_oen;
  logic [3:0]     sd_bcast, m_sd_o, m_oen, m_sd_i;
  logic           m_cs_ram, m_cs_rom, m_sck, busy, tmo;
  logic [1:0]     owner;

  int checks = 0;
  int failures = 0;

  qspi_mem_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_in(rst_n), .en_i(en), .req_i(req), .gnt_o(gnt),
    .req_cs_ram_n_i(r_cs_ram), .req_cs_rom_n_i(r_cs_rom), .req_sck_i(r_sck),
    .req_sd_o_i(r_sd), .req_oen_i(r_oen), .req_sd_i_o(sd_bcast),
    .qspi_mem_cs_ram_on(m_cs_ram), .qspi_mem_cs_rom_on(m_cs_rom),
    .qspi_mem_sck_o(m_sck), .qspi_mem_sd_o(m_sd_o), .qspi_mem_oen_o(m_oen),
    .qspi_mem_sd_i(m_sd_i), .busy_o(busy), .owner_o(owner), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   own;
  } vec_t;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   own;
  } exp_t;

  vec_t tbl[27];
  exp_t sb[$];
  int   rr_q[$];

  // Each requester drives a distinct, always-active pattern.
  function automatic logic [10:0] bus_model(input logic [N-1:0] g);
    logic [10:0] r;
    r = {1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    for (int k = 0; k < N; k++)
      if (g[k]) r = {(k % 2) == 1, (k % 2) == 0, 1'b1, 4'(k + 5), 4'(3 * k + 1)};
    return r;
  endfunction

  function automatic logic [10:0] bus_act();
    return {m_cs_ram, m_cs_rom, m_sck, m_sd_o, m_oen};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    en    = '1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int idle, bad, cnt, tmo_seen, rr_first;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      r_cs_ram[k]     = (k % 2) == 1;
      r_cs_rom[k]     = (k % 2) == 0;
      r_sck[k]        = 1'b1;
      r_sd[4*k +: 4]  = 4'(k + 5);
      r_oen[4*k +: 4] = 4'(3 * k + 1);
    end
    m_sd_i = 4'h0;

    //         en     req    gnt    owner
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 2'd3};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 2'd3};
    tbl[2]  = '{4'hF, 4'h4, 4'h4, 2'd2};   // single grant, 1-cycle latency
    tbl[3]  = '{4'hF, 4'h4, 4'h4, 2'd2};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 2'd2};   // release
    tbl[5]  = '{4'hF, 4'h3, 4'h0, 2'd2};   // new request waits for guard
    tbl[6]  = '{4'hF, 4'h3, 4'h1, 2'd0};   // wraps past 3 to 0
    tbl[7]  = '{4'hF, 4'h3, 4'h1, 2'd0};
    tbl[8]  = '{4'hF, 4'h2, 4'h0, 2'd0};
    tbl[9]  = '{4'hF, 4'h2, 4'h0, 2'd0};
    tbl[10] = '{4'hF, 4'h2, 4'h2, 2'd1};
    tbl[11] = '{4'hD, 4'h3, 4'h0, 2'd1};   // owner enable lost
    tbl[12] = '{4'h2, 4'h3, 4'h0, 2'd1};
    tbl[13] = '{4'h2, 4'h3, 4'h2, 2'd1};   // req0 masked, never granted
    tbl[14] = '{4'h2, 4'h1, 4'h0, 2'd1};
    tbl[15] = '{4'h2, 4'h1, 4'h0, 2'd1};
    tbl[16] = '{4'h2, 4'h1, 4'h0, 2'd1};   // guard ends, nothing eligible
    tbl[17] = '{4'h2, 4'h1, 4'h0, 2'd1};
    tbl[18] = '{4'hF, 4'hA, 4'h8, 2'd3};   // simultaneous: 3 is next after 1
    tbl[19] = '{4'hF, 4'hA, 4'h8, 2'd3};
    tbl[20] = '{4'hF, 4'h2, 4'h0, 2'd3};
    tbl[21] = '{4'hF, 4'h0, 4'h0, 2'd3};
    tbl[22] = '{4'hF, 4'h0, 4'h0, 2'd3};
    tbl[23] = '{4'hF, 4'h5, 4'h1, 2'd0};
    tbl[24] = '{4'hF, 4'h0, 4'h0, 2'd0};
    tbl[25] = '{4'hF, 4'h0, 4'h0, 2'd0};
    tbl[26] = '{4'hF, 4'h0, 4'h0, 2'd0};

    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, N - 1);
    chk("rst_tmo", tmo, 0);
    chk("rst_bus", bus_act(), bus_model('0));

    // Table vectors through the scoreboard.
    for (int i = 0; i < 27; i++) begin
      en     = tbl[i].en;
      req    = tbl[i].req;
      m_sd_i = 4'($urandom_range(0, 15));
      sb.push_back('{tbl[i].gnt, tbl[i].own});
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_gnt", i), gnt, e.gnt);
      chk($sformatf("v%0d_own", i), owner, e.own);
      chk($sformatf("v%0d_busy", i), busy, e.gnt != 0);
      chk($sformatf("v%0d_bus", i), bus_act(), bus_model(e.gnt));
      chk($sformatf("v%0d_sdi", i), sd_bcast, m_sd_i);
      chk($sformatf("v%0d_tmo", i), tmo, 0);
    end

    // Round robin with all four requesting, 10-cycle transactions.
    do_reset();
    rr_q = '{0, 1, 2, 3, 0};
    en = '1;
    req = '1;
    bad = 0;
    rr_first = 1;
    for (int t = 0; t < 5; t++) begin
      int o;
      idle = 0;
      while (gnt == '0 && idle < 20) begin
        if (bus_act() !== bus_model('0)) bad++;
        step();
        idle++;
      end
      o = rr_q.pop_front();
      chk($sformatf("rr%0d_gnt", t), gnt, 1 << o);
      chk($sformatf("rr%0d_bus", t), bus_act(), bus_model(N'(1) << o));
      if (!rr_first) chk($sformatf("rr%0d_gap", t), idle, G);
      rr_first = 0;
      repeat (9) step();
      chk($sformatf("rr%0d_hold", t), gnt, 1 << o);
      req = 4'hF & ~(N'(1) << o);
      step();
      req = 4'hF;
    end
    chk("rr_gap_bus_idle", bad, 0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'h4;
    step();
    chk("mrst_pre", gnt, 4'h4);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_gnt", gnt, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cs", {m_cs_ram, m_cs_rom, m_oen}, {2'b11, 4'h0});
    #2 rst_n = 1'b1;
    req = 4'hF;
    step();
    chk("mrst_prio", gnt, 4'h1);

    // Grant bound.
    do_reset();
    req = 4'h6;
    step();
    chk("tmo_first", gnt, 4'h2);
    cnt = 0;
    tmo_seen = 0;
    while (gnt == 4'h2 && cnt < 120) begin
      if (tmo) tmo_seen++;
      step();
      cnt++;
    end
`ifdef QSPI_ARB_TIMEOUT_EN
    chk("tmo_len", cnt, T);
    chk("tmo_early", tmo_seen, 0);
    chk("tmo_pulse", tmo, 1);
    chk("tmo_drop", gnt, 0);
    step();
    chk("tmo_pulse_end", tmo, 0);
    step();
    chk("tmo_next", gnt, 4'h4);
    req = 4'h2;
    bad = 0;
    repeat (8) begin
      step();
      if (gnt != 0) bad++;
    end
    chk("tmo_blocked", bad, 0);
    req = 4'h0;
    step();
    req = 4'h2;
    step();
    chk("tmo_rearm", gnt, 4'h2);
`else
    chk("notmo_len", cnt, 120);
    chk("notmo_pulse", tmo_seen + int'(tmo), 0);
    chk("notmo_gnt", gnt, 4'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
